// File: rtl/rs_occupancy_ctrl_pkg.sv
// Shared definitions for the reservation-station occupancy controller:
// default depths, hold length, FSM encodings and the count type.
package rs_occupancy_ctrl_pkg;

    localparam int COUNT_W = 4;
    typedef logic [COUNT_W-1:0] rsCountT;

    localparam int RS0_DEPTH_DEF  = 4;
    localparam int RS1_DEPTH_DEF  = 8;
    localparam int RS2_DEPTH_DEF  = 8;
    localparam int RS3_DEPTH_DEF  = 8;
    localparam int FLUSH_HOLD_DEF = 2;

    localparam logic [0:0] STATE_RUN  = 1'b0;
    localparam logic [0:0] STATE_HOLD = 1'b1;

    // A station with fewer than two free entries cannot accept a full dual-slot dispatch.
    function automatic logic nearFull(input rsCountT count, input int depth);
        return (int'(count) + 2) > depth;
    endfunction

endpackage

// File: rtl/rs_occupancy_counter.sv
// Occupancy counter for one reservation station: adds up to two writes, removes
// one issue, saturates at both ends and flags the saturation as an error pulse.
module rs_occupancy_counter
    import rs_occupancy_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    clear,
    input  logic    freeze,
    input  logic    valid0,
    input  logic    valid1,
    input  logic    issue,
    output rsCountT count,
    output logic    error
);

    localparam logic [4:0] DEPTH_W = 5'(DEPTH);

    logic [4:0] grown;
    logic [4:0] nextRaw;
    rsCountT    nextCount;
    logic       underflow;
    logic       overflow;

    // Work at 5 bits so a full station plus two writes never wraps before clamping.
    always_comb begin
        grown     = {1'b0, count} + {4'b0, valid0} + {4'b0, valid1};
        underflow = issue && (grown == 5'd0);
        nextRaw   = grown - {4'b0, issue};
        overflow  = !underflow && (nextRaw > DEPTH_W);
        nextCount = count;
        if (underflow) begin
            nextCount = '0;
        end else if (overflow) begin
            nextCount = DEPTH_W[COUNT_W-1:0];
        end else begin
            nextCount = nextRaw[COUNT_W-1:0];
        end
    end

    assign error = !clear && !freeze && (underflow || overflow);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear || freeze) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/rs_occupancy_ctrl.sv
// Tracks occupancy of the four reservation stations, holds dispatch off for a
// few cycles after a flush and raises a sticky flag on any over/underflow.
module rs_occupancy_ctrl
    import rs_occupancy_ctrl_pkg::*;
#(
    parameter int RS0_DEPTH  = RS0_DEPTH_DEF,
    parameter int RS1_DEPTH  = RS1_DEPTH_DEF,
    parameter int RS2_DEPTH  = RS2_DEPTH_DEF,
    parameter int RS3_DEPTH  = RS3_DEPTH_DEF,
    parameter int FLUSH_HOLD = FLUSH_HOLD_DEF
) (
    input  logic       iCLOCK,
    input  logic       iRESET_SYNC,
    input  logic       iEVENT_FLUSH,
    input  logic       iEXT_LOCK,
    input  logic       iRS0_0_VALID,
    input  logic       iRS0_1_VALID,
    input  logic       iRS0_ISSUE,
    input  logic       iRS1_0_VALID,
    input  logic       iRS1_1_VALID,
    input  logic       iRS1_ISSUE,
    input  logic       iRS2_0_VALID,
    input  logic       iRS2_1_VALID,
    input  logic       iRS2_ISSUE,
    input  logic       iRS3_0_VALID,
    input  logic       iRS3_1_VALID,
    input  logic       iRS3_ISSUE,
    output logic [3:0] oRS0_COUNT,
    output logic [3:0] oRS1_COUNT,
    output logic [3:0] oRS2_COUNT,
    output logic [3:0] oRS3_COUNT,
    output logic       oORDER_LOCK,
    output logic       oOCC_ERROR
);

    logic [0:0] state;
    logic [2:0] holdCnt;
    logic       inHold;
    logic [3:0] stationError;
    logic       occError;

    assign inHold = (state == STATE_HOLD);

    rs_occupancy_counter #(.DEPTH(RS0_DEPTH)) rs0Counter (
        .clock(iCLOCK), .reset(iRESET_SYNC), .clear(iEVENT_FLUSH), .freeze(inHold),
        .valid0(iRS0_0_VALID), .valid1(iRS0_1_VALID), .issue(iRS0_ISSUE),
        .count(oRS0_COUNT), .error(stationError[0])
    );

    rs_occupancy_counter #(.DEPTH(RS1_DEPTH)) rs1Counter (
        .clock(iCLOCK), .reset(iRESET_SYNC), .clear(iEVENT_FLUSH), .freeze(inHold),
        .valid0(iRS1_0_VALID), .valid1(iRS1_1_VALID), .issue(iRS1_ISSUE),
        .count(oRS1_COUNT), .error(stationError[1])
    );

    rs_occupancy_counter #(.DEPTH(RS2_DEPTH)) rs2Counter (
        .clock(iCLOCK), .reset(iRESET_SYNC), .clear(iEVENT_FLUSH), .freeze(inHold),
        .valid0(iRS2_0_VALID), .valid1(iRS2_1_VALID), .issue(iRS2_ISSUE),
        .count(oRS2_COUNT), .error(stationError[2])
    );

    rs_occupancy_counter #(.DEPTH(RS3_DEPTH)) rs3Counter (
        .clock(iCLOCK), .reset(iRESET_SYNC), .clear(iEVENT_FLUSH), .freeze(inHold),
        .valid0(iRS3_0_VALID), .valid1(iRS3_1_VALID), .issue(iRS3_ISSUE),
        .count(oRS3_COUNT), .error(stationError[3])
    );

    // A flush always (re)starts the hold window, even if one is already running.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state   <= STATE_RUN;
            holdCnt <= '0;
        end else if (iEVENT_FLUSH) begin
            state   <= STATE_HOLD;
            holdCnt <= 3'(FLUSH_HOLD - 1);
        end else if (inHold) begin
            if (holdCnt == 3'd0) begin
                state <= STATE_RUN;
            end else begin
                holdCnt <= holdCnt - 3'd1;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            occError <= 1'b0;
        end else if (|stationError) begin
            occError <= 1'b1;
        end
    end

    assign oOCC_ERROR  = occError;
    assign oORDER_LOCK = inHold || iEXT_LOCK
                       || nearFull(oRS0_COUNT, RS0_DEPTH)
                       || nearFull(oRS1_COUNT, RS1_DEPTH)
                       || nearFull(oRS2_COUNT, RS2_DEPTH)
                       || nearFull(oRS3_COUNT, RS3_DEPTH);

endmodule

// File: tb/tb_rs_occupancy_ctrl.sv
// Self-checking bench for rs_occupancy_ctrl: directed scenarios followed by
// randomized traffic compared against a behavioural occupancy model.
module tb_rs_occupancy_ctrl;

    localparam int D0 = 4;
    localparam int D1 = 8;
    localparam int D2 = 8;
    localparam int D3 = 8;
    localparam int HOLD_LEN = 2;

    logic       iCLOCK;
    logic       rst;
    logic       flush;
    logic       ext;
    logic [3:0] v0;
    logic [3:0] v1;
    logic [3:0] iss;
    logic [3:0] c0, c1, c2, c3;
    logic       lock;
    logic       err;

    int checks;
    int failures;

    int mDepth [4];
    int mCount [4];
    int mHoldLeft;
    bit mErr;

    rs_occupancy_ctrl #(
        .RS0_DEPTH(D0), .RS1_DEPTH(D1), .RS2_DEPTH(D2), .RS3_DEPTH(D3), .FLUSH_HOLD(HOLD_LEN)
    ) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(rst), .iEVENT_FLUSH(flush), .iEXT_LOCK(ext),
        .iRS0_0_VALID(v0[0]), .iRS0_1_VALID(v1[0]), .iRS0_ISSUE(iss[0]),
        .iRS1_0_VALID(v0[1]), .iRS1_1_VALID(v1[1]), .iRS1_ISSUE(iss[1]),
        .iRS2_0_VALID(v0[2]), .iRS2_1_VALID(v1[2]), .iRS2_ISSUE(iss[2]),
        .iRS3_0_VALID(v0[3]), .iRS3_1_VALID(v1[3]), .iRS3_ISSUE(iss[3]),
        .oRS0_COUNT(c0), .oRS1_COUNT(c1), .oRS2_COUNT(c2), .oRS3_COUNT(c3),
        .oORDER_LOCK(lock), .oOCC_ERROR(err)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    function automatic int dutCount(input int n);
        case (n)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    // Occupancy bookkeeping from the rules: hold is a count of remaining locked cycles.
    task automatic modelStep();
        if (rst) begin
            foreach (mCount[i]) mCount[i] = 0;
            mHoldLeft = 0;
            mErr = 1'b0;
        end else if (flush) begin
            foreach (mCount[i]) mCount[i] = 0;
            mHoldLeft = HOLD_LEN;
        end else if (mHoldLeft > 0) begin
            mHoldLeft--;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int n;
                n = mCount[i] + int'(v0[i]) + int'(v1[i]) - int'(iss[i]);
                if (n < 0) begin
                    n = 0;
                    mErr = 1'b1;
                end else if (n > mDepth[i]) begin
                    n = mDepth[i];
                    mErr = 1'b1;
                end
                mCount[i] = n;
            end
        end
    endtask

    function automatic bit modelLock();
        bit l;
        l = (mHoldLeft > 0) || ext;
        for (int i = 0; i < 4; i++) if (mDepth[i] - mCount[i] < 2) l = 1'b1;
        return l;
    endfunction

    task automatic tick();
        @(posedge iCLOCK);
        modelStep();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; ext = 1'b0; v0 = '0; v1 = '0; iss = '0;
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dutCount(i) !== 0) begin
                failures++;
                $display("[TB] FAIL reset_count%0d got=%0d want=0", i, dutCount(i));
            end
        end
        checks++;
        if (lock !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got lock=%b err=%b want lock=0 err=0", lock, err);
        end
        ext = 1'b1;
        #1;
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ext_lock got=%b want=1", lock);
        end
        ext = 1'b0;
    endtask

    task automatic test_fill_rs1();
        int want [3] = '{2, 4, 6};
        doReset();
        v0[1] = 1'b1; v1[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (c1 !== 4'(want[k])) begin
                failures++;
                $display("[TB] FAIL fill_rs1_step%0d got=%0d want=%0d", k, c1, want[k]);
            end
        end
        checks++;
        if (lock !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_lock_at6 got=%b want=0", lock);
        end
        v1[1] = 1'b0;
        tick();
        v0[1] = 1'b0;
        checks++;
        if (c1 !== 4'd7 || lock !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fill_lock_at7 got count=%0d lock=%b want count=7 lock=1", c1, lock);
        end
    endtask

    task automatic test_write_issue();
        doReset();
        v0[3] = 1'b1; v1[3] = 1'b1;
        tick(); tick();
        v1[3] = 1'b0;
        tick();
        iss[3] = 1'b1;
        tick();
        idle();
        checks++;
        if (c3 !== 4'd5 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_issue got count=%0d err=%b want count=5 err=0", c3, err);
        end
    endtask

    task automatic test_underflow();
        doReset();
        iss[0] = 1'b1;
        tick();
        iss[0] = 1'b0;
        checks++;
        if (c0 !== 4'd0 || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL underflow got count=%0d err=%b want count=0 err=1", c0, err);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_sticky_flush got=%b want=1", err);
        end
    endtask

    task automatic test_flush_hold();
        doReset();
        v0[2] = 1'b1; v1[2] = 1'b1;
        tick();
        v1[2] = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        v0 = 4'hF; v1 = 4'hF;
        checks++;
        if (c2 !== 4'd0 || lock !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_clear got count=%0d lock=%b want count=0 lock=1", c2, lock);
        end
        tick();
        checks++;
        if (lock !== 1'b1 || c1 !== 4'd0 || c2 !== 4'd0) begin
            failures++;
            $display("[TB] FAIL hold_cycle2 got lock=%b c1=%0d c2=%0d want lock=1 c1=0 c2=0", lock, c1, c2);
        end
        tick();
        idle();
        checks++;
        if (lock !== 1'b0 || c0 !== 4'd0 || c3 !== 4'd0 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_release got lock=%b c0=%0d c3=%0d err=%b want 0 0 0 0", lock, c0, c3, err);
        end
    endtask

    task automatic test_overflow();
        doReset();
        v0[1] = 1'b1; v1[1] = 1'b1;
        tick(); tick(); tick();
        v1[1] = 1'b0;
        tick();
        v1[1] = 1'b1;
        tick();
        idle();
        checks++;
        if (c1 !== 4'd8 || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow got count=%0d err=%b want count=8 err=1", c1, err);
        end
    endtask

    task automatic test_reset_in_hold();
        doReset();
        iss[0] = 1'b1;
        tick();
        idle();
        v0[3] = 1'b1;
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (lock !== 1'b0 || err !== 1'b0 || c3 !== 4'd0 || c0 !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_in_hold got lock=%b err=%b c0=%0d c3=%0d want 0 0 0 0", lock, err, c0, c3);
        end
        v0[1] = 1'b1;
        tick();
        v0[1] = 1'b0;
        checks++;
        if (c1 !== 4'd1) begin
            failures++;
            $display("[TB] FAIL run_after_reset got=%0d want=1", c1);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 19) == 0);
            ext   = ($urandom_range(0, 3) == 0);
            v0    = 4'($urandom);
            v1    = 4'($urandom) & 4'($urandom);
            iss   = 4'($urandom);
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dutCount(i) !== mCount[i]) begin
                    failures++;
                    $display("[TB] FAIL rand_count%0d cyc=%0d got=%0d want=%0d", i, cyc, dutCount(i), mCount[i]);
                end
            end
            checks++;
            if (err !== mErr) begin
                failures++;
                $display("[TB] FAIL rand_err cyc=%0d got=%b want=%b", cyc, err, mErr);
            end
            checks++;
            if (lock !== modelLock()) begin
                failures++;
                $display("[TB] FAIL rand_lock cyc=%0d got=%b want=%b", cyc, lock, modelLock());
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mDepth = '{D0, D1, D2, D3};
        foreach (mCount[i]) mCount[i] = 0;
        mHoldLeft = 0;
        mErr = 1'b0;
        idle();
        test_reset();
        test_fill_rs1();
        test_write_issue();
        test_underflow();
        test_flush_hold();
        test_overflow();
        test_reset_in_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_occupancy_ctrl.md
RS_OCCUPANCY_CTRL -- requirements
Module: rs_occupancy_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RS0_DEPTH, 4, branch RS entry count (1..15)
- RS1_DEPTH, 8, mul/div/ALU RS entry count (1..15)
- RS2_DEPTH, 8, ALU RS entry count (1..15)
- RS3_DEPTH, 8, load/store RS entry count (1..15)
- FLUSH_HOLD, 2, lock cycles after flush (1..7)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- iCLOCK, in, 1, sole clock, rising edge
- iRESET_SYNC, in, 1, synchronous reset, active-high
- iEVENT_FLUSH, in, 1, pipeline flush; empties all RS
- iEXT_LOCK, in, 1, external dispatch stall request
- iRSn_0_VALID (n=0..3), in, 1, order slot 0 written into RSn this cycle
- iRSn_1_VALID (n=0..3), in, 1, order slot 1 written into RSn this cycle
- iRSn_ISSUE (n=0..3), in, 1, one entry leaves RSn this cycle
- oRSn_COUNT (n=0..3), out, 4, occupied entries in RSn
- oORDER_LOCK, out, 1, dispatch must not write any RS this cycle
- oOCC_ERROR, out, 1, sticky overflow/underflow flag

REQ-003 Clock SHALL be iCLOCK only; reset SHALL be iRESET_SYNC, synchronous and active-high.

Function
REQ-004 Per station, next count SHALL be count + RSn_0_VALID + RSn_1_VALID - RSn_ISSUE, computed at 5 bits, registered on the rising edge.
REQ-005 Write and issue in the same cycle SHALL both apply; count stays unchanged for one write plus one issue.
REQ-006 ISSUE with count 0 and no write SHALL leave count 0 and set oOCC_ERROR (underflow).
REQ-007 A result above RSn_DEPTH SHALL clamp to RSn_DEPTH and set oOCC_ERROR (overflow).
REQ-008 oOCC_ERROR SHALL stay set until reset; flush SHALL NOT clear it.
REQ-009 The FSM SHALL have two states.
- RUN: normal operation.
- HOLD: counts forced to 0, hold counter active.
REQ-010 iEVENT_FLUSH in any state SHALL zero all counts and enter HOLD, with the hold counter loaded to FLUSH_HOLD-1 on the next edge.
- Flush SHALL override writes and issues in that same cycle.
- Flush SHALL NOT raise an error.
REQ-011 In HOLD, writes and issues SHALL be ignored, with no error. The counter SHALL decrement each cycle; at 0, the next edge returns to RUN.
REQ-012 oORDER_LOCK SHALL be combinational from registered state and inputs, high when any of:
- state is HOLD;
- iEXT_LOCK is high;
- any station has RSn_DEPTH - oRSn_COUNT < 2.
REQ-013 oRSn_COUNT SHALL be direct register outputs, with zero combinational input-to-output path. The station with depth below 2 SHALL lock permanently; such configurations are illegal.

Reset
REQ-014 On iRESET_SYNC high at an edge, the block SHALL set:
- all counts to 0;
- state to RUN;
- hold counter to 0;
- oOCC_ERROR to 0.
REQ-015 After reset, oORDER_LOCK SHALL be 0 whenever iEXT_LOCK is 0.
REQ-016 Reset SHALL take priority over flush, writes and issues in the same cycle.
REQ-017 Reset asserted while in HOLD SHALL abort HOLD.

Structure
REQ-018 The shared core-defines include SHALL hold the default depths, FLUSH_HOLD and the FSM state encodings (RUN=1'b0, HOLD=1'b1).
REQ-019 One sub-module, rs_occupancy_counter, SHALL be defined, instantiated four times. It is parameterised by DEPTH, implements REQ-004..REQ-007, and has clear (flush) and freeze (HOLD) inputs.
REQ-020 The top level SHALL contain the FSM, hold counter, lock logic and error OR-reduction.

Verification
REQ-021 Reset, then write RS1 on both slots for 3 cycles -> oRS1_COUNT 2,4,6. oORDER_LOCK goes high once count reaches 7 (free < 2); at count 6 it is 0.
REQ-022 RS3 at count 5, then RS3_0_VALID plus RS3_ISSUE in one cycle -> count stays 5; no error.
REQ-023 RS0 at count 0, RS0_ISSUE alone -> count 0, oOCC_ERROR 1 next cycle. A later flush leaves it at 1.
REQ-024 RS2 at count 3, flush plus RS2_0_VALID in one cycle -> RS2 count 0. Lock is high for exactly FLUSH_HOLD=2 cycles, then low; writes during HOLD are ignored.
REQ-025 RS1 at count 7, both valids forced (lock ignored) -> count clamps to 8, oOCC_ERROR 1.
REQ-026 During HOLD with counter at 1, assert iRESET_SYNC -> next cycle state RUN, all counts 0, lock 0, error 0.
